// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - seven-segment pattern constants and digit code type
//
// Segment order {a,b,c,d,e,f,g}: bit 6 = a, active high.

package seg7_pkg;

    typedef logic [3:0] digit_code_t;

    localparam digit_code_t BLANK_CODE = 4'hF;

    localparam logic [6:0] SEG_PAT_0     = 7'b1111110;
    localparam logic [6:0] SEG_PAT_1     = 7'b0110000;
    localparam logic [6:0] SEG_PAT_2     = 7'b1101101;
    localparam logic [6:0] SEG_PAT_3     = 7'b1111001;
    localparam logic [6:0] SEG_PAT_4     = 7'b0110011;
    localparam logic [6:0] SEG_PAT_5     = 7'b1011011;
    localparam logic [6:0] SEG_PAT_6     = 7'b1011111;
    localparam logic [6:0] SEG_PAT_7     = 7'b1110000;
    localparam logic [6:0] SEG_PAT_8     = 7'b1111111;
    localparam logic [6:0] SEG_PAT_9     = 7'b1111011;
    localparam logic [6:0] SEG_PAT_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to BCD decoder
//
// Ports:
//   seg   in  7  segment pattern {a..g}
//   code  out 4  decoded digit, BLANK_CODE for the all-off pattern
//   legal out 1  pattern is one of the ten digits or blank

module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       legal
);

    always_comb begin
        code  = BLANK_CODE;
        legal = 1'b1;
        case (seg)
            SEG_PAT_0:     code = 4'd0;
            SEG_PAT_1:     code = 4'd1;
            SEG_PAT_2:     code = 4'd2;
            SEG_PAT_3:     code = 4'd3;
            SEG_PAT_4:     code = 4'd4;
            SEG_PAT_5:     code = 4'd5;
            SEG_PAT_6:     code = 4'd6;
            SEG_PAT_7:     code = 4'd7;
            SEG_PAT_8:     code = 4'd8;
            SEG_PAT_9:     code = 4'd9;
            SEG_PAT_BLANK: code = BLANK_CODE;
            default:       legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers debounced BCD digits from a scanned 7-seg bus
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   seg_in        7          shared segment lines {a..g}
//   dig_sel       NUM_DIGITS one-hot digit selects
//   bcd_out       4*NUM_DIGITS committed codes, digit i at [4i+3:4i]
//   digit_valid   NUM_DIGITS digit i has committed since reset
//   frame_valid   1          all digits valid
//   update        1          pulse when a committed code changes
//   pattern_err   1          pulse when an accepted sample is not a legal pattern
//   sel_err       1          pulse when more than one select is set

module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int MIN_ON       = 2,
    parameter int STABLE_SCANS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    update,
    output logic                    pattern_err,
    output logic                    sel_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W  = $clog2(MIN_ON + 1);
    localparam logic [ON_W-1:0] ON_SAT    = ON_W'(MIN_ON);
    localparam logic [3:0]      MATCH_SAT = 4'(STABLE_SCANS);

    typedef enum logic {S_IDLE, S_ON} scan_state_t;

    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] sel_q;

    scan_state_t           state;
    logic [IDX_W-1:0]      cur_idx;
    logic [ON_W-1:0]       on_cnt;
    logic [6:0]            held_seg;

    logic                  sel_err_r;
    logic                  pattern_err_r;
    logic                  update_r;

    logic                  sel_multi;
    logic                  sel_one;
    logic [IDX_W-1:0]      sel_idx;
    logic                  close_fire;
    logic                  close_ok;
    digit_code_t           dec_code;
    logic                  dec_legal;
    logic [NUM_DIGITS-1:0] commit_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            seg_q <= seg_in;
            sel_q <= dig_sel;
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means two or more bits.
    assign sel_multi = |(sel_q & (sel_q - NUM_DIGITS'(1)));
    assign sel_one   = (sel_q != '0) && !sel_multi;

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_q[k]) sel_idx = IDX_W'(k);
        end
    end

    // A window closes when its select drops or moves to another digit;
    // a multi-select aborts it instead, so no close is raised then.
    assign close_fire = (state == S_ON) && !sel_multi &&
                        ((sel_q == '0) || (sel_one && (sel_idx != cur_idx)));
    assign close_ok   = close_fire && (on_cnt >= ON_SAT);

    seg7_pattern_decode u_decode (
        .seg   (held_seg),
        .code  (dec_code),
        .legal (dec_legal)
    );

    // The cycle that opens a window already counts as one on-cycle, so
    // on_cnt equals the number of cycles the select was seen active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cur_idx       <= '0;
            on_cnt        <= '0;
            held_seg      <= '0;
            sel_err_r     <= 1'b0;
            pattern_err_r <= 1'b0;
            update_r      <= 1'b0;
        end else begin
            sel_err_r     <= sel_multi;
            pattern_err_r <= close_ok && !dec_legal;
            update_r      <= |commit_vec;
            if (sel_multi) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sel_one) begin
                            state    <= S_ON;
                            cur_idx  <= sel_idx;
                            on_cnt   <= ON_W'(1);
                            held_seg <= seg_q;
                        end
                    end
                    S_ON: begin
                        if (sel_q == '0) begin
                            state <= S_IDLE;
                        end else if (sel_idx != cur_idx) begin
                            cur_idx  <= sel_idx;
                            on_cnt   <= ON_W'(1);
                            held_seg <= seg_q;
                        end else begin
                            held_seg <= seg_q;
                            if (on_cnt != ON_SAT) on_cnt <= on_cnt + ON_W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] cand_r;
        logic [3:0] match_r;
        logic [3:0] code_r;
        logic       valid_r;
        logic       hit;
        logic       commit;

        assign hit    = close_ok && (cur_idx == IDX_W'(i));
        // Once committed, cand_r == code_r keeps a saturated count from re-firing.
        assign commit = (match_r == MATCH_SAT) && (!valid_r || (cand_r != code_r));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cand_r  <= BLANK_CODE;
                match_r <= '0;
                code_r  <= BLANK_CODE;
                valid_r <= 1'b0;
            end else begin
                if (hit) begin
                    if (dec_legal) begin
                        if (dec_code == cand_r) begin
                            if (match_r != MATCH_SAT) match_r <= match_r + 4'd1;
                        end else begin
                            cand_r  <= dec_code;
                            match_r <= 4'd1;
                        end
                    end else begin
                        match_r <= '0;
                    end
                end
                if (commit) begin
                    code_r  <= cand_r;
                    valid_r <= 1'b1;
                end
            end
        end

        assign bcd_out[4*i +: 4] = code_r;
        assign digit_valid[i]    = valid_r;
        assign commit_vec[i]     = commit;
    end

    assign frame_valid = &digit_valid;
    assign update      = update_r;
    assign pattern_err = pattern_err_r;
    assign sel_err     = sel_err_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - self-checking bench for seg7_scan_reader

module tb_seg7_scan_reader;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PB = 7'b0000000;
    localparam logic [6:0] PX = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        update;
    logic        pattern_err;
    logic        sel_err;

    int total = 0;
    int bad = 0;
    int upd_cnt = 0;
    int perr_cnt = 0;
    int serr_cnt = 0;

    seg7_scan_reader #(
        .NUM_DIGITS   (4),
        .MIN_ON       (2),
        .STABLE_SCANS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .update      (update),
        .pattern_err (pattern_err),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (update)      upd_cnt++;
        if (pattern_err) perr_cnt++;
        if (sel_err)     serr_cnt++;
    end

    typedef struct {
        logic [27:0] pats;
        int          scans;
        logic [15:0] exp_bcd;
        int          exp_upd;
        int          exp_perr;
        logic        exp_fv;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Digit d shows pats[7d+6:7d]; every select lasts 4 cycles except digit 1.
    task automatic run_scans(input logic [27:0] pats, input int scans, input int d1_cyc);
        for (int s = 0; s < scans; s++) begin
            for (int d = 0; d < 4; d++) begin
                dig_sel = 4'(1 << d);
                seg_in  = pats[7*d +: 7];
                repeat ((d == 1) ? d1_cyc : 4) @(negedge clk);
            end
        end
        dig_sel = '0;
        seg_in  = '0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int u0;
        int p0;
        int s0;

        tbl[0] = '{{P4, P3, P2, P1}, 3, 16'h4321, 4, 0, 1'b1};
        tbl[1] = '{{P4, P6, P2, P1}, 2, 16'h4321, 0, 0, 1'b1};
        tbl[2] = '{{P4, P3, P2, P1}, 1, 16'h4321, 0, 0, 1'b1};
        tbl[3] = '{{P4, P6, P2, P1}, 3, 16'h4621, 1, 0, 1'b1};
        tbl[4] = '{{P4, P6, P2, P5}, 2, 16'h4621, 0, 0, 1'b1};
        tbl[5] = '{{P4, P6, P2, PX}, 1, 16'h4621, 0, 1, 1'b1};
        tbl[6] = '{{P4, P6, P2, P5}, 1, 16'h4621, 0, 0, 1'b1};
        tbl[7] = '{{P4, P6, P2, P5}, 2, 16'h4625, 1, 0, 1'b1};
        tbl[8] = '{{PB, P6, P2, P5}, 3, 16'hF625, 1, 0, 1'b1};
        tbl[9] = '{{P7, P9, P8, P0}, 3, 16'h7980, 4, 0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_bcd", 32'(bcd_out), 32'hFFFF);
        check("rst_valid", 32'(digit_valid), 32'h0);
        check("rst_frame", 32'(frame_valid), 32'h0);
        check("rst_pulses", {29'd0, update, pattern_err, sel_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            u0 = upd_cnt;
            p0 = perr_cnt;
            run_scans(tbl[v].pats, tbl[v].scans, 4);
            check($sformatf("vec%0d_bcd", v), 32'(bcd_out), 32'(tbl[v].exp_bcd));
            check($sformatf("vec%0d_update", v), 32'(upd_cnt - u0), 32'(tbl[v].exp_upd));
            check($sformatf("vec%0d_perr", v), 32'(perr_cnt - p0), 32'(tbl[v].exp_perr));
            check($sformatf("vec%0d_frame", v), 32'(frame_valid), 32'(tbl[v].exp_fv));
        end

        // Digit 1 select held for a single cycle: below MIN_ON, ignored.
        u0 = upd_cnt; p0 = perr_cnt; s0 = serr_cnt;
        run_scans({P7, P9, P3, P0}, 3, 1);
        check("short_bcd", 32'(bcd_out), 32'h7980);
        check("short_update", 32'(upd_cnt - u0), 32'd0);
        check("short_errs", 32'((perr_cnt - p0) + (serr_cnt - s0)), 32'd0);

        // Exactly MIN_ON cycles is accepted.
        u0 = upd_cnt;
        run_scans({P7, P9, P3, P0}, 3, 2);
        check("minon_bcd", 32'(bcd_out), 32'h7930);
        check("minon_update", 32'(upd_cnt - u0), 32'd1);

        // Multi-select glitch aborts the digit 0 window each time.
        u0 = upd_cnt; p0 = perr_cnt; s0 = serr_cnt;
        for (int r = 0; r < 3; r++) begin
            dig_sel = 4'b0001; seg_in = P6;
            repeat (2) @(negedge clk);
            dig_sel = 4'b0110;
            @(negedge clk);
            dig_sel = 4'b0000; seg_in = '0;
            repeat (4) @(negedge clk);
        end
        check("selerr_count", 32'(serr_cnt - s0), 32'd3);
        check("selerr_bcd", 32'(bcd_out), 32'h7930);
        check("selerr_update", 32'(upd_cnt - u0), 32'd0);
        check("selerr_perr", 32'(perr_cnt - p0), 32'd0);

        // Reset asserted in the middle of an open window.
        dig_sel = 4'b0001; seg_in = P5;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_bcd", 32'(bcd_out), 32'hFFFF);
        check("midrst_valid", 32'(digit_valid), 32'h0);
        check("midrst_frame", 32'(frame_valid), 32'h0);
        check("midrst_pulses", {29'd0, update, pattern_err, sel_err}, 32'h0);
        dig_sel = '0; seg_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        u0 = upd_cnt;
        run_scans({P4, P3, P2, P1}, 2, 4);
        check("rescan2_valid", 32'(digit_valid), 32'h0);
        check("rescan2_bcd", 32'(bcd_out), 32'hFFFF);
        run_scans({P4, P3, P2, P1}, 1, 4);
        check("rescan3_bcd", 32'(bcd_out), 32'h4321);
        check("rescan3_frame", 32'(frame_valid), 32'h1);
        check("rescan3_update", 32'(upd_cnt - u0), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
